// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA tile path and the tile RAM arbiter.
//   - 640x480 frame timing (800x525 total), 16x16 tiles, 40x30 tile map
//   - arb_state_t: states of the tile RAM arbiter FSM
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 480;
  localparam int V_TOTAL    = 525;

  localparam int TILE_SHIFT = 4;
  localparam int COLS       = 40;
  localparam int ROWS       = 30;

  // Last in-line prefetch happens one tile before the end of the active area;
  // the first tile of the next line is fetched one tile before the line ends.
  localparam logic [9:0] H_PREFETCH_END = 10'(H_ACTIVE - (1 << TILE_SHIFT));
  localparam logic [9:0] H_LINE_FETCH   = 10'(H_TOTAL  - (1 << TILE_SHIFT));
  localparam logic [9:0] V_LAST         = 10'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRD  = 3'd1,
    DCAP = 3'd2,
    GACC = 3'd3,
    GRSP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: combinational decode of the display prefetch trigger and
// the tile swap point, plus row/col to tile RAM address.
// Ports:
//   pixen           one-CLK pixel enable
//   hcoord, vcoord  beam position
//   trig            a prefetch slot occurs this cycle
//   fetch_ok        trig and the target row lies inside the tile map
//   swap            load the prefetched tile into the current-tile register
//   addr            row*40+col of the tile to prefetch
module tile_addr_gen
  import vga_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              pixen,
  input  logic [9:0]        hcoord,
  input  logic [9:0]        vcoord,
  output logic              trig,
  output logic              fetch_ok,
  output logic              swap,
  output logic [ADDR_W-1:0] addr
);

  logic [5:0] row;
  logic [5:0] col;
  logic [5:0] nxt_row;
  logic       in_active;
  logic       at_wrap;

  always_comb begin
    // Tile row of the following line, wrapping after the last line.
    if (vcoord == V_LAST)
      nxt_row = 6'd0;
    else if (vcoord[3:0] == 4'hF)
      nxt_row = vcoord[9:4] + 6'd1;
    else
      nxt_row = vcoord[9:4];

    in_active = (hcoord < H_PREFETCH_END);
    at_wrap   = (hcoord == H_LINE_FETCH);
    trig      = pixen && (hcoord[3:0] == 4'd0) && (in_active || at_wrap);

    if (at_wrap) begin
      row = nxt_row;
      col = 6'd0;
    end else begin
      row = vcoord[9:4];
      col = hcoord[9:4] + 6'd1;
    end

    // Rows 30..32 fall in vertical blanking: nothing to fetch there.
    fetch_ok = trig && (row < 6'(ROWS));
    // row*40 as row*32 + row*8.
    addr     = ADDR_W'({row, 5'b0}) + ADDR_W'({row, 3'b0}) + ADDR_W'(col);
    swap     = pixen && (hcoord[3:0] == 4'hF);
  end

endmodule

// File: rtl/vga_tile_arbiter.sv
// vga_tile_arbiter: shares a single-port tile RAM between the display
// prefetch (always first) and game-logic accesses served in the gaps.
// Ports:
//   CLK, ARST                  clock, asynchronous active-high reset
//   PIXEN, HCOORD, VCOORD      pixel enable and beam position
//   RAM_ADDR/WE/WDATA/RDATA    tile RAM port (read data one CLK after address)
//   GREQ/GWE/GADDR/GWDATA      game request
//   GACK, GRDATA               game completion pulse and read data
//   TILE_CUR                   tile code under the beam
//   OVERRUN                    sticky: a prefetch slot came while one was pending
//   dbg_state                  current arbiter FSM state
// Game handshake: GREQ is sampled only in IDLE while GACK=0; the request
// fields are latched on grant, GACK pulses one CLK three cycles after the
// grant with GRDATA valid in that cycle, and the requester drops GREQ in the
// GACK cycle. A reset abandons an in-flight access without any GACK.
module vga_tile_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              ARST,
  input  logic              PIXEN,
  input  logic [9:0]        HCOORD,
  input  logic [9:0]        VCOORD,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  input  logic              GREQ,
  input  logic              GWE,
  input  logic [ADDR_W-1:0] GADDR,
  input  logic [DATA_W-1:0] GWDATA,
  output logic              GACK,
  output logic [DATA_W-1:0] GRDATA,
  output logic [DATA_W-1:0] TILE_CUR,
  output logic              OVERRUN,
  output logic [2:0]        dbg_state
);

  arb_state_t        state, state_nxt;
  logic              disp_pend;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] g_addr;
  logic              g_we;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W-1:0] tile_next;

  logic              trig;
  logic              fetch_ok;
  logic              swap;
  logic [ADDR_W-1:0] fetch_addr;
  logic              disp_req;
  logic              grant;

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .pixen    (PIXEN),
    .hcoord   (HCOORD),
    .vcoord   (VCOORD),
    .trig     (trig),
    .fetch_ok (fetch_ok),
    .swap     (swap),
    .addr     (fetch_addr)
  );

  // A trigger arriving in the same cycle as GREQ already counts as a display
  // request, so the display wins the tie; disp_addr is registered by then.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    disp_req  = disp_pend | fetch_ok;
    case (state)
      IDLE: begin
        if (disp_req)
          state_nxt = DRD;
        else if (GREQ && !GACK) begin
          state_nxt = GACC;
          grant     = 1'b1;
        end
      end
      DRD:     state_nxt = DCAP;
      DCAP:    state_nxt = IDLE;
      GACC:    state_nxt = GRSP;
      GRSP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_WDATA = '0;
    case (state)
      DRD:  RAM_ADDR = disp_addr;
      GACC: begin
        RAM_ADDR  = g_addr;
        RAM_WE    = g_we;
        RAM_WDATA = g_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state     <= IDLE;
      disp_pend <= 1'b0;
      disp_addr <= '0;
      g_addr    <= '0;
      g_we      <= 1'b0;
      g_wdata   <= '0;
      tile_next <= '0;
      GACK      <= 1'b0;
      GRDATA    <= '0;
      TILE_CUR  <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      state <= state_nxt;
      GACK  <= (state == GRSP);

      if (grant) begin
        g_addr  <= GADDR;
        g_we    <= GWE;
        g_wdata <= GWDATA;
      end

      if (state == GRSP)
        GRDATA <= RAM_RDATA;

      if (state == DCAP) begin
        tile_next <= RAM_RDATA;
        disp_pend <= 1'b0;
      end

      // Placed after the DCAP update so a fresh fetch overrides the clear.
      if (trig) begin
        if (disp_pend)
          OVERRUN <= 1'b1;
        if (fetch_ok) begin
          disp_addr <= fetch_addr;
          disp_pend <= 1'b1;
        end else begin
          tile_next <= '0;
        end
      end

      if (swap)
        TILE_CUR <= tile_next;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// Bench for vga_tile_arbiter: directed vectors against a behavioural tile RAM.
module tb_vga_tile_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRD  = 3'd1;
  localparam logic [2:0] S_DCAP = 3'd2;
  localparam logic [2:0] S_GACC = 3'd3;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        ARST;
  logic        PIXEN;
  logic [9:0]  HCOORD, VCOORD;
  logic [10:0] RAM_ADDR;
  logic        RAM_WE;
  logic [3:0]  RAM_WDATA;
  logic [3:0]  ram_rdata;
  logic        GREQ, GWE;
  logic [10:0] GADDR;
  logic [3:0]  GWDATA;
  logic        GACK;
  logic [3:0]  GRDATA, TILE_CUR;
  logic        OVERRUN;
  logic [2:0]  dbg_state;

  always #5 CLK = ~CLK;

  vga_tile_arbiter dut (
    .CLK       (CLK),
    .ARST      (ARST),
    .PIXEN     (PIXEN),
    .HCOORD    (HCOORD),
    .VCOORD    (VCOORD),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_WE    (RAM_WE),
    .RAM_WDATA (RAM_WDATA),
    .RAM_RDATA (ram_rdata),
    .GREQ      (GREQ),
    .GWE       (GWE),
    .GADDR     (GADDR),
    .GWDATA    (GWDATA),
    .GACK      (GACK),
    .GRDATA    (GRDATA),
    .TILE_CUR  (TILE_CUR),
    .OVERRUN   (OVERRUN),
    .dbg_state (dbg_state)
  );

  // ---------------- tile RAM model ----------------
  logic [3:0]  mem [0:2047];
  logic        ld_en = 1'b0;
  logic [10:0] ld_addr = '0;
  logic [3:0]  ld_data = '0;

  always @(posedge CLK) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (RAM_WE)
      mem[RAM_ADDR] <= RAM_WDATA;
    ram_rdata <= mem[RAM_ADDR];
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    HCOORD = h;
    VCOORD = v;
    PIXEN  = 1'b1;
    tick();
    PIXEN  = 1'b0;
  endtask

  task automatic load(input logic [10:0] a, input logic [3:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic game_op(input string tag, input logic we, input logic [10:0] a,
                         input logic [3:0] d, input logic [3:0] exp_rd);
    int lat;
    GREQ = 1'b1; GWE = we; GADDR = a; GWDATA = d;
    tick(); lat = 1;
    check({tag, "_grant"}, 32'(dbg_state), 32'(S_GACC));
    check({tag, "_we"}, 32'(RAM_WE), 32'(we));
    check({tag, "_addr"}, 32'(RAM_ADDR), 32'(a));
    if (we) check({tag, "_wdata"}, 32'(RAM_WDATA), 32'(d));
    tick(); lat = 2;
    check({tag, "_we_drop"}, 32'(RAM_WE), 32'd0);
    while (GACK !== 1'b1 && lat < 12) begin tick(); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    if (!we) check({tag, "_rdata"}, 32'(GRDATA), 32'(exp_rd));
    GREQ = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 32'(GACK), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int acks;
    ARST = 1'b1; PIXEN = 1'b0; HCOORD = '0; VCOORD = '0;
    GREQ = 1'b0; GWE = 1'b0; GADDR = '0; GWDATA = '0;
    tick(); tick();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_outs", {RAM_ADDR, RAM_WE, RAM_WDATA, GACK, GRDATA, TILE_CUR, OVERRUN}, 32'd0);
    ARST = 1'b0;
    tick();

    load(11'd81, 4'd7);
    load(11'd0, 4'd5);
    load(11'd39, 4'd3);
    load(11'd5, 4'd0);

    // Address calc: VCOORD=35 -> row 2, HCOORD=0 -> col 1
    pix(10'd0, 10'd35);
    check("calc_state", 32'(dbg_state), 32'(S_DRD));
    check("calc_addr", 32'(RAM_ADDR), 32'd81);
    check("calc_we", 32'(RAM_WE), 32'd0);
    tick();
    check("calc_dcap", 32'(dbg_state), 32'(S_DCAP));
    tick();
    check("calc_idle", 32'(dbg_state), 32'(S_IDLE));
    check("cur_before_swap", 32'(TILE_CUR), 32'd0);
    pix(10'd15, 10'd35);
    check("cur_swap", 32'(TILE_CUR), 32'd7);

    // Last in-line prefetch: HCOORD=608 -> col 39, row 0
    pix(10'd608, 10'd0);
    check("col39_addr", 32'(RAM_ADDR), 32'd39);
    tick(); tick();
    pix(10'd623, 10'd0);
    check("col39_cur", 32'(TILE_CUR), 32'd3);

    // No trigger in horizontal blanking before 784
    pix(10'd640, 10'd0);
    check("no_fetch_640", 32'(dbg_state), 32'(S_IDLE));

    // Row 30 is off the map: blank tile without RAM access
    pix(10'd0, 10'd480);
    check("row30_noacc", 32'(dbg_state), 32'(S_IDLE));
    pix(10'd15, 10'd480);
    check("row30_blank", 32'(TILE_CUR), 32'd0);

    // Line wrap: last line -> row 0 col 0
    pix(10'd784, 10'd524);
    check("wrap_state", 32'(dbg_state), 32'(S_DRD));
    check("wrap_addr", 32'(RAM_ADDR), 32'd0);
    tick(); tick();
    pix(10'd799, 10'd524);
    check("wrap_cur", 32'(TILE_CUR), 32'd5);
    pix(10'd784, 10'd479);
    check("wrap479_noacc", 32'(dbg_state), 32'(S_IDLE));
    pix(10'd799, 10'd479);
    check("wrap479_cur", 32'(TILE_CUR), 32'd0);

    // Game write then read back at the top address
    game_op("gwr", 1'b1, 11'd1199, 4'hA, 4'h0);
    game_op("grd", 1'b0, 11'd1199, 4'h0, 4'hA);

    // Collision: display trigger and GREQ in the same cycle
    GREQ = 1'b1; GWE = 1'b0; GADDR = 11'd81;
    HCOORD = 10'd0; VCOORD = 10'd35; PIXEN = 1'b1;
    tick(); lat = 1;
    PIXEN = 1'b0;
    check("coll_drd_first", 32'(dbg_state), 32'(S_DRD));
    check("coll_drd_addr", 32'(RAM_ADDR), 32'd81);
    tick(); tick(); tick(); lat = 4;
    check("coll_gacc", 32'(dbg_state), 32'(S_GACC));
    while (GACK !== 1'b1 && lat < 14) begin tick(); lat++; end
    check("coll_lat", 32'(lat), 32'd6);
    check("coll_rdata", 32'(GRDATA), 32'd7);
    check("coll_overrun", 32'(OVERRUN), 32'd0);
    GREQ = 1'b0;
    tick();
    pix(10'd15, 10'd35);
    check("coll_cur", 32'(TILE_CUR), 32'd7);

    // Held GREQ: no regrant in the GACK cycle, regrant the cycle after
    GREQ = 1'b1; GWE = 1'b0; GADDR = 11'd39;
    lat = 0;
    while (GACK !== 1'b1 && lat < 12) begin tick(); lat++; end
    check("held_lat", 32'(lat), 32'd3);
    check("held_rdata", 32'(GRDATA), 32'd3);
    tick();
    check("held_no_regrant", {29'd0, dbg_state}, 32'(S_IDLE));
    check("held_ack_low", 32'(GACK), 32'd0);
    tick();
    check("held_regrant", 32'(dbg_state), 32'(S_GACC));
    GREQ = 1'b0;
    lat = 0;
    while (GACK !== 1'b1 && lat < 12) begin tick(); lat++; end
    check("held_second_ack", 32'(GACK), 32'd1);
    tick();

    // Two back-to-back triggers force a missed deadline
    HCOORD = 10'd0; VCOORD = 10'd0; PIXEN = 1'b1;
    tick(); tick();
    PIXEN = 1'b0;
    check("overrun_set", 32'(OVERRUN), 32'd1);
    tick(); tick(); tick();

    // Reset while a game write sits in GACC
    GREQ = 1'b1; GWE = 1'b1; GADDR = 11'd5; GWDATA = 4'd3;
    tick();
    check("rst_pre_we", 32'(RAM_WE), 32'd1);
    #2 ARST = 1'b1;
    #1;
    check("rst_we_async", 32'(RAM_WE), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_mid_outs", {RAM_ADDR, RAM_WE, RAM_WDATA, GACK, GRDATA, TILE_CUR, OVERRUN}, 32'd0);
    GREQ = 1'b0;
    tick();
    ARST = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (GACK === 1'b1) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    check("rst_no_write", 32'(mem[5]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
